// File: rtl/xup_logic_pkg.sv
// xup_logic_pkg: shared definitions for the bitwise logic vector accumulator.
//   - Op-code constants (OP_OR .. OP_XACC) for the 3-bit op select.
//   - FSM state type for the accumulate frame controller (ST_IDLE, ST_ACC).
//   - is_acc_op(): true for the two accumulate op-codes (110, 111).
package xup_logic_pkg;

  localparam logic [2:0] OP_OR   = 3'b000;
  localparam logic [2:0] OP_AND  = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_NOR  = 3'b011;
  localparam logic [2:0] OP_NAND = 3'b100;
  localparam logic [2:0] OP_XNOR = 3'b101;
  localparam logic [2:0] OP_OACC = 3'b110;
  localparam logic [2:0] OP_XACC = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } state_e;

  // Both accumulate codes share the pattern 11x.
  function automatic logic is_acc_op(input logic [2:0] op);
    return (op[2:1] == 2'b11);
  endfunction

endpackage

// File: rtl/xup_logic_vector_alu.sv
// xup_logic_vector_alu: combinational bitwise operator.
// Ports:
//   a, b        [SIZE-1:0] in   operands
//   op          [2:0]      in   operation select (see xup_logic_pkg)
//   acc         [SIZE-1:0] in   running accumulator, used by the 11x ops only
//   next_value  [SIZE-1:0] out  f(a,b) for direct ops, folded value for 11x ops
module xup_logic_vector_alu
  import xup_logic_pkg::*;
#(
  parameter int SIZE = 8
) (
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  input  logic [2:0]      op,
  input  logic [SIZE-1:0] acc,
  output logic [SIZE-1:0] next_value
);

  always_comb begin
    next_value = '0;
    case (op)
      OP_OR:   next_value = a | b;
      OP_AND:  next_value = a & b;
      OP_XOR:  next_value = a ^ b;
      OP_NOR:  next_value = ~(a | b);
      OP_NAND: next_value = ~(a & b);
      OP_XNOR: next_value = ~(a ^ b);
      OP_OACC: next_value = acc | (a | b);
      OP_XACC: next_value = acc ^ (a ^ b);
      default: next_value = '0;
    endcase
  end

endmodule

// File: rtl/xup_logic_vector_acc.sv
// xup_logic_vector_acc: registered, valid/ready handshaked bitwise vector unit.
// Direct ops (000-101) produce one result per accepted beat with 1-cycle
// latency. Accumulate ops (110 OR-acc, 111 XOR-acc) fold ACC_LEN beats into
// one result; the op of the first beat of a frame is latched and used for the
// whole frame.
// Ports:
//   clk, reset (async, active-high)
//   in_valid / in_ready, a, b [SIZE-1:0], op [2:0]     input beat handshake
//   out_valid / out_ready, y [SIZE-1:0], out_last      result handshake
// Optional (macro XUP_LOGIC_VECTOR_STATS_EN):
//   beat_cnt [15:0]   accepted input beats, saturating
//   frame_cnt [15:0]  transferred results, saturating
// DELAY is a simulation-only output delay; it has no effect on cycle behaviour
// and is not modelled here.
module xup_logic_vector_acc
  import xup_logic_pkg::*;
#(
  parameter int SIZE    = 8,
  parameter int ACC_LEN = 4,
  parameter int DELAY   = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  input  logic [2:0]      op,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE-1:0] y,
  output logic            out_last
`ifdef XUP_LOGIC_VECTOR_STATS_EN
  ,output logic [15:0]    beat_cnt
  ,output logic [15:0]    frame_cnt
`endif
);

  localparam int CW = $clog2(ACC_LEN + 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(ACC_LEN - 1);

  if (SIZE < 1 || ACC_LEN < 1 || DELAY < 0) begin : g_bad_param
    $error("xup_logic_vector_acc: illegal parameter value");
  end

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SIZE-1:0] acc_q, acc_d;
  logic [2:0]      op_q, op_d;
  logic [SIZE-1:0] y_q, y_d;
  logic            valid_q, valid_d;
  logic            last_q, last_d;

  logic            accept;
  logic            transfer;
  logic [2:0]      alu_op;
  logic [SIZE-1:0] alu_value;

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign transfer = valid_q && out_ready;

  // Inside a frame the live op input is ignored in favour of the latched op.
  // acc_q is always zero in IDLE, so the fold ops yield a|b / a^b there.
  assign alu_op = (state_q == ST_ACC) ? op_q : op;

  xup_logic_vector_alu #(
    .SIZE(SIZE)
  ) u_alu (
    .a          (a),
    .b          (b),
    .op         (alu_op),
    .acc        (acc_q),
    .next_value (alu_value)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    op_d    = op_q;
    y_d     = y_q;
    last_d  = last_q;
    // A transfer frees the output slot; a load below may refill it.
    valid_d = transfer ? 1'b0 : valid_q;

    if (accept) begin
      if (state_q == ST_IDLE) begin
        if (is_acc_op(op)) begin
          op_d = op;
          if (ACC_LEN == 1) begin
            y_d     = alu_value;
            valid_d = 1'b1;
            last_d  = 1'b1;
            cnt_d   = '0;
            acc_d   = '0;
          end else begin
            acc_d   = alu_value;
            cnt_d   = CW'(1);
            state_d = ST_ACC;
          end
        end else begin
          y_d     = alu_value;
          valid_d = 1'b1;
          last_d  = 1'b1;
        end
      end else begin
        if (cnt_q == LAST_BEAT) begin
          y_d     = alu_value;
          valid_d = 1'b1;
          last_d  = 1'b1;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = ST_IDLE;
        end else begin
          acc_d = alu_value;
          cnt_d = cnt_q + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      op_q    <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      op_q    <= op_d;
      y_q     <= y_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign y         = y_q;
  assign out_valid = valid_q;
  assign out_last  = last_q;

`ifdef XUP_LOGIC_VECTOR_STATS_EN
  logic [15:0] beat_cnt_q;
  logic [15:0] frame_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat_cnt_q  <= '0;
      frame_cnt_q <= '0;
    end else begin
      if (accept && beat_cnt_q != 16'hFFFF) beat_cnt_q <= beat_cnt_q + 16'd1;
      if (transfer && frame_cnt_q != 16'hFFFF) frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign beat_cnt  = beat_cnt_q;
  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_xup_logic_vector_acc.sv
// Self-checking bench for xup_logic_vector_acc: directed test-plan steps and a
// randomized run, checked against a frame-level reference model. A second
// instance with ACC_LEN=1 covers the single-beat frame case.
module tb_xup_logic_vector_acc;

  localparam int SIZE    = 8;
  localparam int ACC_LEN = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid, in_ready, out_valid, out_ready, out_last;
  logic [7:0] a, b, y;
  logic [2:0] op;

  logic       in_valid1, in_ready1, out_valid1, out_ready1, out_last1;
  logic [7:0] a1, b1, y1;
  logic [2:0] op1;

`ifdef XUP_LOGIC_VECTOR_STATS_EN
  logic [15:0] beat_cnt, frame_cnt, beat_cnt1, frame_cnt1;
`endif

  always #5 clk = ~clk;

  xup_logic_vector_acc #(.SIZE(SIZE), .ACC_LEN(ACC_LEN), .DELAY(0)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .op(op),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .out_last(out_last)
`ifdef XUP_LOGIC_VECTOR_STATS_EN
    , .beat_cnt(beat_cnt), .frame_cnt(frame_cnt)
`endif
  );

  xup_logic_vector_acc #(.SIZE(SIZE), .ACC_LEN(1), .DELAY(0)) dut1 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid1), .in_ready(in_ready1), .a(a1), .b(b1), .op(op1),
    .out_valid(out_valid1), .out_ready(out_ready1), .y(y1), .out_last(out_last1)
`ifdef XUP_LOGIC_VECTOR_STATS_EN
    , .beat_cnt(beat_cnt1), .frame_cnt(frame_cnt1)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Reference model: pending output slot plus the list of folded beat values
  // of the frame currently being collected.
  logic       m_valid;
  logic [7:0] m_y;
  logic [2:0] frame_op;
  logic [7:0] frame_vals[$];
  int         m_beats, m_frames;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] z);
    case (o)
      3'd0: return x | z;
      3'd1: return x & z;
      3'd2: return x ^ z;
      3'd3: return ~(x | z);
      3'd4: return ~(x & z);
      default: return ~(x ^ z);
    endcase
  endfunction

  function automatic logic [7:0] fold(input logic [2:0] o);
    logic [7:0] r = 8'h00;
    foreach (frame_vals[i]) r = o[0] ? (r ^ frame_vals[i]) : (r | frame_vals[i]);
    return r;
  endfunction

  task automatic model_reset();
    m_valid  = 1'b0;
    m_y      = 8'h00;
    frame_op = 3'd0;
    frame_vals.delete();
    m_beats  = 0;
    m_frames = 0;
  endtask

  // One clock cycle on the main instance; called right after a falling edge.
  task automatic step(input logic iv, input logic [7:0] ia, input logic [7:0] ib,
                      input logic [2:0] iop, input logic ordy);
    logic exp_rdy, acc, xfer;
    in_valid = iv; a = ia; b = ib; op = iop; out_ready = ordy;
    #1;
    exp_rdy = !m_valid || ordy;
    check("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    acc  = iv && exp_rdy;
    xfer = m_valid && ordy;
    @(posedge clk);
    if (xfer) begin
      m_valid = 1'b0;
      m_frames++;
      $display("t=%0t transfer y=%02h", $time, m_y);
    end
    if (acc) begin
      m_beats++;
      if (frame_vals.size() == 0 && iop[2:1] != 2'b11) begin
        m_y = ref_op(iop, ia, ib);
        m_valid = 1'b1;
      end else begin
        if (frame_vals.size() == 0) frame_op = iop;
        frame_vals.push_back(frame_op[0] ? (ia ^ ib) : (ia | ib));
        if (frame_vals.size() == ACC_LEN) begin
          m_y = fold(frame_op);
          frame_vals.delete();
          m_valid = 1'b1;
        end
      end
    end
    @(negedge clk);
    check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    if (m_valid) begin
      check("y", {24'd0, y}, {24'd0, m_y});
      check("out_last", {31'd0, out_last}, 32'd1);
    end
`ifdef XUP_LOGIC_VECTOR_STATS_EN
    check("beat_cnt", {16'd0, beat_cnt}, m_beats);
    check("frame_cnt", {16'd0, frame_cnt}, m_frames);
`endif
  endtask

  logic [7:0] direct_exp[6];

  initial begin
    direct_exp[0] = 8'hFC; direct_exp[1] = 8'h30; direct_exp[2] = 8'hCC;
    direct_exp[3] = 8'h03; direct_exp[4] = 8'hCF; direct_exp[5] = 8'h33;

    reset = 1'b1;
    in_valid = 0; a = 0; b = 0; op = 0; out_ready = 0;
    in_valid1 = 0; a1 = 0; b1 = 0; op1 = 0; out_ready1 = 0;
    model_reset();

    // Reset state
    @(negedge clk); @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_y", {24'd0, y}, 32'd0);
    check("rst_out_last", {31'd0, out_last}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    reset = 1'b0;

    // Direct ops, back to back with out_ready high
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 8'hF0, 8'h3C, 3'(i), 1'b1);
      check("direct_y", {24'd0, y}, {24'd0, direct_exp[i]});
      check("direct_last", {31'd0, out_last}, 32'd1);
    end
    step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);

    // OR-accumulate frame
    step(1'b1, 8'h01, 8'h00, 3'b110, 1'b1);
    check("oacc_beat1_valid", {31'd0, out_valid}, 32'd0);
    step(1'b1, 8'h00, 8'h02, 3'b000, 1'b1);
    check("oacc_beat2_valid", {31'd0, out_valid}, 32'd0);
    step(1'b1, 8'h04, 8'h00, 3'b000, 1'b1);
    check("oacc_beat3_valid", {31'd0, out_valid}, 32'd0);
    step(1'b1, 8'h00, 8'h80, 3'b000, 1'b1);
    check("oacc_y", {24'd0, y}, 32'h87);
    check("oacc_last", {31'd0, out_last}, 32'd1);
    step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
    check("oacc_single", {31'd0, out_valid}, 32'd0);

    // XOR-accumulate; op input changes mid-frame and must be ignored
    step(1'b1, 8'hFF, 8'h00, 3'b111, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 8'hFF, 8'h00, 3'b000, 1'b1);
    check("xacc_y", {24'd0, y}, 32'h00);
    check("xacc_valid", {31'd0, out_valid}, 32'd1);
    step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);

    // Backpressure then simultaneous transfer and load
    step(1'b1, 8'h12, 8'h34, 3'b000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 8'h55, 8'h66, 3'b001, 1'b0);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_y_hold", {24'd0, y}, 32'h36);
    end
    step(1'b1, 8'h0F, 8'hF0, 3'b010, 1'b1);
    check("bp_reload_valid", {31'd0, out_valid}, 32'd1);
    check("bp_reload_y", {24'd0, y}, 32'hFF);
    step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);

    // Asynchronous reset while a result is pending
    step(1'b1, 8'hAA, 8'h55, 3'b000, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("async_out_valid", {31'd0, out_valid}, 32'd0);
    check("async_y", {24'd0, y}, 32'd0);
    check("async_out_last", {31'd0, out_last}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();

    // Reset mid-frame discards the partial accumulation
    step(1'b1, 8'h01, 8'h00, 3'b110, 1'b1);
    step(1'b1, 8'h02, 8'h00, 3'b110, 1'b1);
    #2 reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    step(1'b1, 8'h10, 8'h00, 3'b110, 1'b1);
    step(1'b1, 8'h20, 8'h00, 3'b110, 1'b1);
    step(1'b1, 8'h40, 8'h00, 3'b110, 1'b1);
    step(1'b1, 8'h00, 8'h80, 3'b110, 1'b1);
    check("discard_y", {24'd0, y}, 32'hF0);
    step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);

    // ACC_LEN=1 instance: accumulate ops emit every beat
    in_valid1 = 1'b1; a1 = 8'h0A; b1 = 8'h50; op1 = 3'b110; out_ready1 = 1'b1;
    @(posedge clk); @(negedge clk);
    check("len1_oacc_valid", {31'd0, out_valid1}, 32'd1);
    check("len1_oacc_y", {24'd0, y1}, 32'h5A);
    check("len1_oacc_last", {31'd0, out_last1}, 32'd1);
    $display("t=%0t len1 transfer y=%02h", $time, y1);
    a1 = 8'h0F; b1 = 8'hFF; op1 = 3'b111;
    @(posedge clk); @(negedge clk);
    check("len1_xacc_y", {24'd0, y1}, 32'hF0);
    in_valid1 = 1'b0;
    @(posedge clk); @(negedge clk);
    check("len1_idle_valid", {31'd0, out_valid1}, 32'd0);
`ifdef XUP_LOGIC_VECTOR_STATS_EN
    check("len1_beat_cnt", {16'd0, beat_cnt1}, 32'd2);
    check("len1_frame_cnt", {16'd0, frame_cnt1}, 32'd2);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 4) != 0, 8'($urandom), 8'($urandom), 3'($urandom),
           ($urandom % 3) != 0);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
